// File: rtl/denoise_stream_sync.sv
`default_nettype none
// ============================================================================
// Module      : denoise_stream_sync
// Description : Frame-alignment controller for denoise_core. Drops beats on
//               each input until both previous- and current-frame streams sit
//               on a start-of-frame beat. Then it releases them in lockstep as
//               one joint {curr,prev} stream. On any tlast/tuser disagreement
//               it drops the offending pair and resynchronises.
// Options     : `define DENOISE_SYNC_STATS_EN enables the frame/drop counters.
//               Without it, frame_cnt and drop_cnt read 0.
// Revision    : 1.0 - initial release
// ============================================================================
module denoise_stream_sync #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [DATA_WIDTH-1:0]   s_prev_axis_tdata,
  input  logic                    s_prev_axis_tvalid,
  input  logic                    s_prev_axis_tlast,
  input  logic                    s_prev_axis_tuser,
  output logic                    s_prev_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s_curr_axis_tdata,
  input  logic                    s_curr_axis_tvalid,
  input  logic                    s_curr_axis_tlast,
  input  logic                    s_curr_axis_tuser,
  output logic                    s_curr_axis_tready,
  output logic [2*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  output logic                    sync_locked,
  output logic                    resync_pulse,
  output logic [CNT_W-1:0]        frame_cnt,
  output logic [CNT_W-1:0]        drop_cnt
);

  localparam logic [0:0] ST_SEEK = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]              r_state;
  logic                    r_active;   // inputs stay stalled for the first cycle out of reset
  logic [2*DATA_WIDTH-1:0] r_m_tdata;
  logic                    r_m_tvalid;
  logic                    r_m_tlast;
  logic                    r_m_tuser;
  logic                    r_resync;

  logic w_slot_free;
  logic w_both_valid;
  logic w_seek_join;
  logic w_run_acc;
  logic w_agree;
  logic w_fwd;
  logic w_mismatch;

  assign w_slot_free  = !r_m_tvalid | m_axis_tready;
  assign w_both_valid = s_prev_axis_tvalid & s_curr_axis_tvalid;
  // Both heads on SOF: take the pair together and lock.
  assign w_seek_join  = (r_state == ST_SEEK) & r_active & w_both_valid &
                        s_prev_axis_tuser & s_curr_axis_tuser & w_slot_free;
  assign w_run_acc    = (r_state == ST_RUN) & w_both_valid & w_slot_free;
  assign w_agree      = (s_prev_axis_tlast == s_curr_axis_tlast) &
                        (s_prev_axis_tuser == s_curr_axis_tuser);
  assign w_fwd        = w_seek_join | (w_run_acc & w_agree);
  assign w_mismatch   = w_run_acc & !w_agree;

  // Input handshakes: independent drop/hold while seeking, joint accept when locked.
  always_comb begin
    s_prev_axis_tready = 1'b0;
    s_curr_axis_tready = 1'b0;
    if (r_state == ST_RUN) begin
      s_prev_axis_tready = w_run_acc;
      s_curr_axis_tready = w_run_acc;
    end else if (r_active) begin
      s_prev_axis_tready = !s_prev_axis_tuser | w_seek_join;
      s_curr_axis_tready = !s_curr_axis_tuser | w_seek_join;
    end
  end

  // Lock state, resync pulse and the post-reset enable.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= ST_SEEK;
      r_active <= 1'b0;
      r_resync <= 1'b0;
    end else begin
      r_active <= 1'b1;
      r_resync <= w_mismatch;
      if (w_seek_join) begin
        r_state <= ST_RUN;
      end else if (w_mismatch) begin
        r_state <= ST_SEEK;
      end
    end
  end

  // Single-register output stage; contents hold while downstream stalls.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_m_tdata  <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tuser  <= 1'b0;
    end else if (w_fwd) begin
      r_m_tdata  <= {s_curr_axis_tdata, s_prev_axis_tdata};
      r_m_tvalid <= 1'b1;
      r_m_tlast  <= s_prev_axis_tlast & s_curr_axis_tlast;
      r_m_tuser  <= s_prev_axis_tuser & s_curr_axis_tuser;
    end else if (m_axis_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;
  assign m_axis_tuser  = r_m_tuser;
  assign sync_locked   = (r_state == ST_RUN);
  assign resync_pulse  = r_resync;

`ifdef DENOISE_SYNC_STATS_EN
  logic [CNT_W-1:0] r_frame_cnt;
  logic [CNT_W-1:0] r_drop_cnt;
  logic             w_prev_drop;
  logic             w_curr_drop;
  logic [1:0]       w_drop_inc;
  logic [CNT_W:0]   w_drop_sum;

  assign w_prev_drop = (r_state == ST_SEEK) & r_active & s_prev_axis_tvalid & !s_prev_axis_tuser;
  assign w_curr_drop = (r_state == ST_SEEK) & r_active & s_curr_axis_tvalid & !s_curr_axis_tuser;
  assign w_drop_inc  = w_mismatch ? 2'd2 : ({1'b0, w_prev_drop} + {1'b0, w_curr_drop});
  assign w_drop_sum  = {1'b0, r_drop_cnt} + {{(CNT_W-1){1'b0}}, w_drop_inc};

  // Saturating statistics: frames forwarded and input beats discarded.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_fwd && s_prev_axis_tuser && s_curr_axis_tuser && (r_frame_cnt != '1)) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
      r_drop_cnt <= w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign drop_cnt  = r_drop_cnt;
`else
  assign frame_cnt = '0;
  assign drop_cnt  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_denoise_stream_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_denoise_stream_sync
// Description : Directed bench for denoise_stream_sync: alignment, offset
//               start, backpressure, mismatch resync, mid-frame reset and
//               counter saturation (counters expected 0 unless
//               DENOISE_SYNC_STATS_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_denoise_stream_sync;

  localparam int DW = 16;
  localparam int CW = 4;
`ifdef DENOISE_SYNC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [DW-1:0] s_prev_axis_tdata, s_curr_axis_tdata;
  logic          s_prev_axis_tvalid, s_prev_axis_tlast, s_prev_axis_tuser, s_prev_axis_tready;
  logic          s_curr_axis_tvalid, s_curr_axis_tlast, s_curr_axis_tuser, s_curr_axis_tready;
  logic [2*DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic          mrdy;
  logic          sync_locked, resync_pulse;
  logic [CW-1:0] frame_cnt, drop_cnt;

  typedef logic [DW+1:0]   beat_t;   // {tuser, tlast, tdata}
  typedef logic [2*DW+1:0] obeat_t;  // {tuser, tlast, {curr, prev}}
  beat_t  pq[$];
  beat_t  cq[$];
  obeat_t outq[$];

  int n_cmp = 0;
  int n_err = 0;
  int n_resync = 0;
  int cyc = 0;
  bit bp_en = 1'b0;

  always #5 aclk = ~aclk;

  denoise_stream_sync #(.DATA_WIDTH(DW), .CNT_W(CW)) u_dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .s_prev_axis_tdata  (s_prev_axis_tdata),
    .s_prev_axis_tvalid (s_prev_axis_tvalid),
    .s_prev_axis_tlast  (s_prev_axis_tlast),
    .s_prev_axis_tuser  (s_prev_axis_tuser),
    .s_prev_axis_tready (s_prev_axis_tready),
    .s_curr_axis_tdata  (s_curr_axis_tdata),
    .s_curr_axis_tvalid (s_curr_axis_tvalid),
    .s_curr_axis_tlast  (s_curr_axis_tlast),
    .s_curr_axis_tuser  (s_curr_axis_tuser),
    .s_curr_axis_tready (s_curr_axis_tready),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tready      (mrdy),
    .m_axis_tlast       (m_axis_tlast),
    .m_axis_tuser       (m_axis_tuser),
    .sync_locked        (sync_locked),
    .resync_pulse       (resync_pulse),
    .frame_cnt          (frame_cnt),
    .drop_cnt           (drop_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_cnt(input int v);
    if (!STATS) return 64'd0;
    return (v > 15) ? 64'd15 : 64'(v);
  endfunction

  // Present the head of each source queue.
  task automatic present();
    if (pq.size() > 0) begin
      s_prev_axis_tvalid = 1'b1;
      {s_prev_axis_tuser, s_prev_axis_tlast, s_prev_axis_tdata} = pq[0];
    end else begin
      s_prev_axis_tvalid = 1'b0;
      {s_prev_axis_tuser, s_prev_axis_tlast, s_prev_axis_tdata} = '0;
    end
    if (cq.size() > 0) begin
      s_curr_axis_tvalid = 1'b1;
      {s_curr_axis_tuser, s_curr_axis_tlast, s_curr_axis_tdata} = cq[0];
    end else begin
      s_curr_axis_tvalid = 1'b0;
      {s_curr_axis_tuser, s_curr_axis_tlast, s_curr_axis_tdata} = '0;
    end
  endtask

  task automatic load();
    present();
    #1;
  endtask

  task automatic push_frame(input int sel, input logic [DW-1:0] base, input int last_err);
    beat_t b;
    for (int i = 0; i < 16; i++) begin
      b = {(i == 0), ((i % 4) == 3) || (i == last_err), base + DW'(i)};
      if (sel == 0) pq.push_back(b); else cq.push_back(b);
    end
  endtask

  task automatic push_junk(input int sel, input int n, input logic [DW-1:0] base);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b = {1'b0, 1'b0, base + DW'(i)};
      if (sel == 0) pq.push_back(b); else cq.push_back(b);
    end
  endtask

  // One clock: sample handshakes before the edge, update sources after it.
  task automatic cycle();
    logic   pf, cf, held;
    obeat_t hv;
    pf   = s_prev_axis_tvalid && s_prev_axis_tready;
    cf   = s_curr_axis_tvalid && s_curr_axis_tready;
    held = m_axis_tvalid && !mrdy;
    hv   = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    if (m_axis_tvalid && mrdy) outq.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
    if (resync_pulse) n_resync++;
    if (bp_en && held) begin
      check_eq("bp_prev_tready", s_prev_axis_tready, 0);
      check_eq("bp_curr_tready", s_curr_axis_tready, 0);
    end
    @(posedge aclk);
    #1;
    if (pf) void'(pq.pop_front());
    if (cf) void'(cq.pop_front());
    cyc++;
    if (bp_en) mrdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    present();
    #1;
    if (held) check_eq("stall_hold", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}, {1'b1, hv});
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic run_until(input int n, input int budget, input string tag);
    int c = 0;
    while (outq.size() < n && c < budget) begin
      cycle();
      c++;
    end
    check_eq(tag, outq.size(), n);
  endtask

  task automatic check_frame(input int first, input logic [DW-1:0] pb, input logic [DW-1:0] cb, input string tag);
    obeat_t e;
    if (outq.size() >= first + 16) begin
      for (int i = 0; i < 16; i++) begin
        e = {(i == 0), ((i % 4) == 3), cb + DW'(i), pb + DW'(i)};
        check_eq(tag, outq[first + i], e);
      end
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    pq.delete();
    cq.delete();
    outq.delete();
    bp_en = 1'b0;
    mrdy  = 1'b1;
    present();
    repeat (2) @(posedge aclk);
    #1;
    aresetn  = 1'b1;
    n_resync = 0;
    #1;
  endtask

  initial begin
    obeat_t e;
    // Reset state with live-looking inputs
    aresetn = 1'b0;
    mrdy    = 1'b1;
    pq.push_back('0);
    cq.push_back('0);
    present();
    #3;
    check_eq("rst_m_tvalid", m_axis_tvalid, 0);
    check_eq("rst_m_tdata", m_axis_tdata, 0);
    check_eq("rst_prev_tready", s_prev_axis_tready, 0);
    check_eq("rst_curr_tready", s_curr_axis_tready, 0);
    check_eq("rst_locked", sync_locked, 0);
    check_eq("rst_resync", resync_pulse, 0);
    check_eq("rst_frame_cnt", frame_cnt, 0);
    check_eq("rst_drop_cnt", drop_cnt, 0);

    // 1: aligned 4x4 frame
    do_reset();
    push_frame(0, 16'h1000, -1);
    push_frame(1, 16'h2000, -1);
    load();
    run_until(16, 60, "t1_count");
    check_frame(0, 16'h1000, 16'h2000, "t1_beat");
    check_eq("t1_locked", sync_locked, 1);
    check_eq("t1_frame_cnt", frame_cnt, exp_cnt(1));
    check_eq("t1_drop_cnt", drop_cnt, exp_cnt(0));

    // 2: prev offset by 3 junk beats
    do_reset();
    push_junk(0, 3, 16'hE000);
    push_frame(0, 16'h1000, -1);
    push_frame(1, 16'h2000, -1);
    load();
    cycle();
    check_eq("t2_prev_drop_rdy", s_prev_axis_tready, 1);
    check_eq("t2_curr_held", s_curr_axis_tready, 0);
    run_until(16, 60, "t2_count");
    check_frame(0, 16'h1000, 16'h2000, "t2_beat");
    check_eq("t2_drop_cnt", drop_cnt, exp_cnt(3));

    // 3: backpressure pattern 1,0,0,1
    do_reset();
    push_frame(0, 16'h1100, -1);
    push_frame(1, 16'h2200, -1);
    cyc   = 0;
    bp_en = 1'b1;
    mrdy  = 1'b1;
    load();
    run_until(16, 120, "t3_count");
    bp_en = 1'b0;
    mrdy  = 1'b1;
    check_frame(0, 16'h1100, 16'h2200, "t3_beat");

    // 4: tlast mismatch on beat 5, relock on next SOF
    do_reset();
    push_frame(0, 16'h1000, 4);
    push_frame(1, 16'h2000, -1);
    push_frame(0, 16'h5000, -1);
    push_frame(1, 16'h6000, -1);
    load();
    run_until(20, 150, "t4_count");
    if (outq.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        e = {(i == 0), (i == 3), 16'h2000 + DW'(i), 16'h1000 + DW'(i)};
        check_eq("t4_pre_beat", outq[i], e);
      end
    end
    check_frame(4, 16'h5000, 16'h6000, "t4_relock_beat");
    check_eq("t4_resync_cycles", n_resync, 1);
    check_eq("t4_locked", sync_locked, 1);
    check_eq("t4_frame_cnt", frame_cnt, exp_cnt(2));
    check_eq("t4_drop_cnt", drop_cnt, exp_cnt(24));

    // 5: reset mid-frame
    do_reset();
    push_frame(0, 16'h1000, -1);
    push_frame(1, 16'h2000, -1);
    load();
    run_until(6, 40, "t5_pre_count");
    aresetn = 1'b0;
    #1;
    check_eq("t5_m_tvalid", m_axis_tvalid, 0);
    check_eq("t5_m_tdata", m_axis_tdata, 0);
    check_eq("t5_prev_tready", s_prev_axis_tready, 0);
    check_eq("t5_locked", sync_locked, 0);
    outq.delete();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    push_frame(0, 16'h3000, -1);
    push_frame(1, 16'h4000, -1);
    load();
    run_until(16, 80, "t5_post_count");
    check_frame(0, 16'h3000, 16'h4000, "t5_beat");

    // 6: drop counter saturation
    do_reset();
    push_junk(0, 10, 16'hE000);
    push_junk(1, 10, 16'hF000);
    load();
    run(15);
    check_eq("t6_drop_sat", drop_cnt, exp_cnt(20));
    check_eq("t6_no_output", outq.size(), 0);
    check_eq("t6_unlocked", sync_locked, 0);
    run(5);
    check_eq("t6_drop_hold", drop_cnt, exp_cnt(20));
    check_eq("t6_frame_cnt", frame_cnt, exp_cnt(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
